// File: rtl/mips_core.sv
// mips_core: 5-stage pipelined MIPS-like core (IF, ID, EX, MEM, WB).
// Instructions are loaded into imem while ProgMode=0 and executed while
// ProgMode=1. The core has no outputs. Its state is observed hierarchically
// through regfile, dmem and pc.
//
// Ports
//   clk        : single clock; all state changes on its rising edge
//   reset      : asynchronous active-low reset (clears pc, pipeline, regfile)
//   ProgMode   : 0 = program imem / hold pipeline, 1 = run
//   Addr_Prog  : imem write address (program mode)
//   Data_Prog  : imem write data (program mode)
module mips_core (
    input logic        clk,
    input logic        reset,
    input logic        ProgMode,
    input logic [7:0]  Addr_Prog,
    input logic [31:0] Data_Prog
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h01, OP_SW = 6'h02,
                           OP_ADDI = 6'h04, OP_BNE = 6'h0D, OP_JMP = 6'h3F;
    localparam logic [5:0] FN_AND = 6'h08, FN_SRL = 6'h19, FN_ADD = 6'h20,
                           FN_SUB = 6'h22, FN_OR = 6'h25, FN_XOR = 6'h26,
                           FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SRL
    } alu_op_t;

    // ra is the destination (field A); we is already cleared for R0 targets
    typedef struct packed {
        logic        we;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vc;
        logic [31:0] imm;
        alu_op_t     alu;
        logic        use_imm;
        logic        is_load;
        logic        is_store;
        logic        is_bne;
        logic        is_jmp;
    } id_ex_t;

    logic [31:0] imem    [256];
    logic [31:0] dmem    [256];
    logic [31:0] regfile [32];
    logic [7:0]  pc;

    logic [31:0] if_id_instr;
    id_ex_t      id_ex, id_dec;
    logic        id_uses_a, id_uses_b, id_uses_c, load_use;

    logic        ex_mem_we, ex_mem_is_load, ex_mem_is_store;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_val, ex_mem_sdata;

    logic        mem_wb_we;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_val;

    logic [31:0] ex_a, ex_b, ex_c, ex_op2, ex_result, mem_result;
    logic        ex_taken;

    // ID read with bypass of the write that WB performs this same cycle
    function automatic logic [31:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        if (mem_wb_we && mem_wb_rd == idx) return mem_wb_val;
        return regfile[idx];
    endfunction

    // EX operand forwarding; EX/MEM wins. Loads never sit in EX/MEM with a
    // consumer in EX because of the load-use stall, so they are skipped there.
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] val);
        if (idx == 5'd0) return val;
        if (ex_mem_we && !ex_mem_is_load && ex_mem_rd == idx) return ex_mem_val;
        if (mem_wb_we && mem_wb_rd == idx) return mem_wb_val;
        return val;
    endfunction

    always_comb begin
        id_dec         = '0;
        id_uses_a      = 1'b0;
        id_uses_b      = 1'b0;
        id_uses_c      = 1'b0;
        id_dec.ra      = if_id_instr[25:21];
        id_dec.rb      = if_id_instr[20:16];
        id_dec.rc      = if_id_instr[15:11];
        id_dec.va      = read_reg(if_id_instr[25:21]);
        id_dec.vb      = read_reg(if_id_instr[20:16]);
        id_dec.vc      = read_reg(if_id_instr[15:11]);
        id_dec.imm     = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        id_dec.alu     = ALU_ADD;
        case (if_id_instr[31:26])
            OP_RTYPE: begin
                id_dec.we = 1'b1;
                id_uses_b = 1'b1;
                id_uses_c = 1'b1;
                case (if_id_instr[5:0])
                    FN_AND:  id_dec.alu = ALU_AND;
                    FN_SRL:  id_dec.alu = ALU_SRL;
                    FN_ADD:  id_dec.alu = ALU_ADD;
                    FN_SUB:  id_dec.alu = ALU_SUB;
                    FN_OR:   id_dec.alu = ALU_OR;
                    FN_XOR:  id_dec.alu = ALU_XOR;
                    FN_SLT:  id_dec.alu = ALU_SLT;
                    default: begin
                        id_dec.we = 1'b0;
                        id_uses_b = 1'b0;
                        id_uses_c = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                id_dec.we      = 1'b1;
                id_dec.use_imm = 1'b1;
                id_uses_b      = 1'b1;
            end
            OP_LW: begin
                id_dec.we      = 1'b1;
                id_dec.use_imm = 1'b1;
                id_dec.is_load = 1'b1;
                id_uses_b      = 1'b1;
            end
            OP_SW: begin
                id_dec.use_imm  = 1'b1;
                id_dec.is_store = 1'b1;
                id_uses_a       = 1'b1;
                id_uses_b       = 1'b1;
            end
            OP_BNE: begin
                id_dec.is_bne = 1'b1;
                id_uses_a     = 1'b1;
                id_uses_b     = 1'b1;
            end
            OP_JMP:  id_dec.is_jmp = 1'b1;
            default: ;
        endcase
        if (if_id_instr[25:21] == 5'd0) id_dec.we = 1'b0;
    end

    always_comb begin
        load_use = id_ex.is_load && id_ex.we &&
                   ((id_uses_a && id_dec.ra == id_ex.ra) ||
                    (id_uses_b && id_dec.rb == id_ex.ra) ||
                    (id_uses_c && id_dec.rc == id_ex.ra));
    end

    always_comb begin
        ex_a   = fwd(id_ex.ra, id_ex.va);
        ex_b   = fwd(id_ex.rb, id_ex.vb);
        ex_c   = fwd(id_ex.rc, id_ex.vc);
        ex_op2 = id_ex.use_imm ? id_ex.imm : ex_c;
        case (id_ex.alu)
            ALU_SUB: ex_result = ex_b - ex_op2;
            ALU_AND: ex_result = ex_b & ex_op2;
            ALU_OR:  ex_result = ex_b | ex_op2;
            ALU_XOR: ex_result = ex_b ^ ex_op2;
            ALU_SLT: ex_result = {31'b0, $signed(ex_b) < $signed(ex_op2)};
            ALU_SRL: ex_result = ex_b >> ex_c[4:0];
            default: ex_result = ex_b + ex_op2;
        endcase
        ex_taken   = id_ex.is_jmp || (id_ex.is_bne && (ex_a != ex_b));
        mem_result = ex_mem_is_load ? dmem[ex_mem_val[7:0]] : ex_mem_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc              <= '0;
            if_id_instr     <= '0;
            id_ex           <= '0;
            ex_mem_we       <= 1'b0;
            ex_mem_is_load  <= 1'b0;
            ex_mem_is_store <= 1'b0;
            ex_mem_rd       <= '0;
            ex_mem_val      <= '0;
            ex_mem_sdata    <= '0;
            mem_wb_we       <= 1'b0;
            mem_wb_rd       <= '0;
            mem_wb_val      <= '0;
        end else if (!ProgMode) begin
            pc              <= '0;
            if_id_instr     <= '0;
            id_ex           <= '0;
            ex_mem_we       <= 1'b0;
            ex_mem_is_load  <= 1'b0;
            ex_mem_is_store <= 1'b0;
            ex_mem_rd       <= '0;
            ex_mem_val      <= '0;
            ex_mem_sdata    <= '0;
            mem_wb_we       <= 1'b0;
            mem_wb_rd       <= '0;
            mem_wb_val      <= '0;
        end else begin
            if (ex_taken) begin
                pc          <= id_ex.imm[7:0];
                if_id_instr <= '0;
                id_ex       <= '0;
            end else if (load_use) begin
                id_ex <= '0;
            end else begin
                pc          <= pc + 8'd1;
                if_id_instr <= imem[pc];
                id_ex       <= id_dec;
            end
            ex_mem_we       <= id_ex.we;
            ex_mem_is_load  <= id_ex.is_load;
            ex_mem_is_store <= id_ex.is_store;
            ex_mem_rd       <= id_ex.ra;
            ex_mem_val      <= ex_result;
            ex_mem_sdata    <= ex_a;
            mem_wb_we       <= ex_mem_we;
            mem_wb_rd       <= ex_mem_rd;
            mem_wb_val      <= mem_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end else if (mem_wb_we) begin
            regfile[mem_wb_rd] <= mem_wb_val;
        end
    end

    // imem and dmem are deliberately outside reset so programs and data survive it
    always_ff @(posedge clk) begin
        if (reset && !ProgMode) imem[Addr_Prog] <= Data_Prog;
    end

    always_ff @(posedge clk) begin
        if (reset && ProgMode && ex_mem_is_store) dmem[ex_mem_val[7:0]] <= ex_mem_sdata;
    end
endmodule

// File: tb/tb_mips_core.sv
module tb_mips_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ProgMode = 1'b0;
    logic [7:0]  Addr_Prog = '0;
    logic [31:0] Data_Prog = '0;

    always #5 clk = ~clk;

    mips_core dut (
        .clk(clk), .reset(reset), .ProgMode(ProgMode),
        .Addr_Prog(Addr_Prog), .Data_Prog(Data_Prog)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        int          cyc;   // cycles after run start, -1 = any
    } wb_t;

    wb_t exp_q[$];
    int  total = 0, bad = 0;
    int  cyc = 0, base = 0;

    logic [31:0] p27 [11] = '{32'h10600DDE, 32'h10400000, 32'h10200001, 32'h00811808,
                              32'h34810006, 32'h10420001, 32'h00630819, 32'h34600003,
                              32'h08400005, 32'h06000005, 32'hFC00000A};

    always @(posedge clk) cyc <= cyc + 1;

    // writeback monitor: every register write in WB must match the queue head
    always @(negedge clk) begin
        wb_t e;
        if (reset && dut.mem_wb_we && dut.mem_wb_rd != 5'd0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got R%0d=%h at cycle %0d, required no write",
                         dut.mem_wb_rd, dut.mem_wb_val, cyc - base);
            end else begin
                e = exp_q.pop_front();
                if (dut.mem_wb_rd != e.rd || dut.mem_wb_val != e.val ||
                    (e.cyc >= 0 && (cyc - base) != e.cyc)) begin
                    bad++;
                    $display("FAIL wb_R%0d: got R%0d=%h at cycle %0d, required R%0d=%h at cycle %0d",
                             e.rd, dut.mem_wb_rd, dut.mem_wb_val, cyc - base, e.rd, e.val, e.cyc);
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] a,
                                          input logic [4:0] b, input logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] c, input logic [5:0] fn);
        return {6'h00, a, b, c, 5'h00, fn};
    endfunction

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] val, input int c);
        wb_t e;
        e.rd = rd; e.val = val; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_reset_state(input string name);
        int nz = 0;
        for (int i = 0; i < 32; i++) if (dut.regfile[i] != 32'h0) nz++;
        check({name, "_pc"}, {24'h0, dut.pc}, 32'h0);
        check({name, "_nonzero_regs"}, nz, 32'h0);
    endtask

    task automatic prog_word(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        ProgMode  = 1'b0;
        Addr_Prog = addr;
        Data_Prog = data;
    endtask

    // reset pulse, then switch to run mode; base marks the negedge before fetch of addr 0
    task automatic start_run(input string name);
        @(negedge clk);
        ProgMode = 1'b0;
        reset    = 1'b0;
        #1;
        check_reset_state(name);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ProgMode = 1'b1;
        base     = cyc;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d writebacks pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    // ISA-level trace of the bit-count program
    task automatic push_27();
        logic [31:0] r3 = 32'd3550;
        logic [31:0] r2 = 32'd0;
        expect_wb(3, 32'd3550, -1);
        expect_wb(2, 32'd0, -1);
        expect_wb(1, 32'd1, -1);
        while (r3 != 0) begin
            expect_wb(4, r3 & 32'd1, -1);
            if (r3[0]) begin
                r2 = r2 + 1;
                expect_wb(2, r2, -1);
            end
            r3 = r3 >> 1;
            expect_wb(3, r3, -1);
        end
        expect_wb(16, r2, -1);
    endtask

    task automatic check_27(input string name);
        check({name, "_R2"}, dut.regfile[2], 32'd9);
        check({name, "_R3"}, dut.regfile[3], 32'd0);
        check({name, "_R16"}, dut.regfile[16], 32'd9);
        check({name, "_dmem5"}, dut.dmem[5], 32'd9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (dut.pc < 8'd10 || dut.pc > 8'd12) begin
                bad++;
                $display("FAIL %s_pc_halt: got %0d, required 10..12", name, dut.pc);
            end
        end
    endtask

    initial begin
        #1;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b1;

        // back-to-back forwarding, no stalls
        prog_word(0, enc_i(6'h04, 1, 0, 16'd5));
        prog_word(1, enc_i(6'h04, 1, 1, 16'd1));
        prog_word(2, enc_r(2, 1, 1, 6'h20));
        prog_word(3, enc_i(6'h3F, 0, 0, 16'd3));
        start_run("fwd");
        expect_wb(1, 32'd5, 4);
        expect_wb(1, 32'd6, 5);
        expect_wb(2, 32'd12, 6);
        wait_drain("fwd", 50);
        check("fwd_R1", dut.regfile[1], 32'd6);
        check("fwd_R2", dut.regfile[2], 32'd12);

        // ALU ops, signed compare, logical shift, non-writing opcodes
        prog_word(0, enc_i(6'h04, 1, 0, 16'hFFFD));
        prog_word(1, enc_i(6'h04, 2, 0, 16'h00F0));
        prog_word(2, enc_r(3, 2, 1, 6'h22));
        prog_word(3, enc_r(4, 1, 2, 6'h25));
        prog_word(4, enc_r(5, 1, 2, 6'h26));
        prog_word(5, enc_r(6, 1, 2, 6'h2A));
        prog_word(6, enc_r(7, 2, 1, 6'h2A));
        prog_word(7, enc_r(8, 1, 2, 6'h19));
        prog_word(8, enc_r(11, 1, 2, 6'h08));
        prog_word(9, enc_i(6'h3A, 9, 1, 16'h0000));
        prog_word(10, enc_r(10, 1, 2, 6'h00));
        prog_word(11, enc_i(6'h3F, 0, 0, 16'd11));
        start_run("alu");
        expect_wb(1, 32'hFFFFFFFD, 4);
        expect_wb(2, 32'h000000F0, 5);
        expect_wb(3, 32'h000000F3, 6);
        expect_wb(4, 32'hFFFFFFFD, 7);
        expect_wb(5, 32'hFFFFFF0D, 8);
        expect_wb(6, 32'd1, 9);
        expect_wb(7, 32'd0, 10);
        expect_wb(8, 32'h0000FFFF, 11);
        expect_wb(11, 32'h000000F0, 12);
        wait_drain("alu", 60);
        check("alu_R9", dut.regfile[9], 32'd0);
        check("alu_R10", dut.regfile[10], 32'd0);

        // store, load, load-use: one stall moves ADDI R5 from cycle 7 to 8
        prog_word(0, enc_i(6'h04, 1, 0, 16'd7));
        prog_word(1, enc_i(6'h02, 1, 0, 16'd3));
        prog_word(2, enc_i(6'h01, 4, 0, 16'd3));
        prog_word(3, enc_i(6'h04, 5, 4, 16'd1));
        prog_word(4, enc_i(6'h3F, 0, 0, 16'd4));
        start_run("ldst");
        expect_wb(1, 32'd7, 4);
        expect_wb(4, 32'd7, 6);
        expect_wb(5, 32'd8, 8);
        wait_drain("ldst", 60);
        check("ldst_dmem3", dut.dmem[3], 32'd7);
        check("ldst_R5", dut.regfile[5], 32'd8);

        // taken BNE flushes two ADDI R6; not-taken BNE flushes nothing
        prog_word(0, enc_i(6'h04, 8, 0, 16'd1));
        prog_word(1, enc_i(6'h0D, 8, 0, 16'd4));
        prog_word(2, enc_i(6'h04, 6, 0, 16'd1));
        prog_word(3, enc_i(6'h04, 6, 0, 16'd2));
        prog_word(4, enc_i(6'h0D, 0, 0, 16'd7));
        prog_word(5, enc_i(6'h04, 9, 0, 16'd3));
        prog_word(6, enc_i(6'h04, 10, 0, 16'd4));
        prog_word(7, enc_i(6'h3F, 0, 0, 16'd7));
        start_run("bne");
        expect_wb(8, 32'd1, 4);
        expect_wb(9, 32'd3, 9);
        expect_wb(10, 32'd4, 10);
        wait_drain("bne", 60);
        check("bne_R6", dut.regfile[6], 32'd0);

        // R0 stays zero and is never forwarded
        prog_word(0, enc_i(6'h04, 0, 0, 16'd5));
        prog_word(1, enc_r(7, 0, 0, 6'h20));
        prog_word(2, enc_i(6'h3F, 0, 0, 16'd2));
        start_run("r0");
        expect_wb(7, 32'd0, 5);
        wait_drain("r0", 50);
        check("r0_R0", dut.regfile[0], 32'd0);

        // PC wrap 255 -> 0
        prog_word(0, enc_i(6'h0D, 12, 0, 16'd2));
        prog_word(1, enc_i(6'h3F, 0, 0, 16'h00FF));
        prog_word(2, enc_i(6'h3F, 0, 0, 16'd2));
        prog_word(255, enc_i(6'h04, 12, 0, 16'd7));
        start_run("wrap");
        expect_wb(12, 32'd7, 8);
        wait_drain("wrap", 60);
        check("wrap_R12", dut.regfile[12], 32'd7);
        check("wrap_pc_lo", {31'h0, dut.pc >= 8'd2 && dut.pc <= 8'd4}, 32'd1);

        // bit-count program
        for (int i = 0; i < 11; i++) prog_word(i[7:0], p27[i]);
        start_run("p27");
        push_27();
        wait_drain("p27", 600);
        check_27("p27");

        // same program, reset asserted mid-run, imem left intact
        start_run("p27r");
        push_27();
        repeat (40) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("p27_midreset");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        base  = cyc;
        push_27();
        wait_drain("p27r", 600);
        check_27("p27r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_core.md
MIPS_CORE -- requirements
Module: MIPS

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ProgMode, input, 1 bit: 0 = program (instruction-memory write) mode; 1 = run mode.
REQ-004 SHALL have port Addr_Prog, input, 8 bits: instruction-memory write address.
REQ-005 SHALL have port Data_Prog, input, 32 bits: instruction word to write.
REQ-006 SHALL have no output ports; the 32x32 register file (regfile), 256x32 data memory (dmem) and 8-bit PC (pc) SHALL be hierarchically observable under these names.

Function
REQ-007 SHALL contain a 256x32 instruction memory (imem), a 256x32 data memory, and a 32x32 register file with R0 hardwired to 0.
REQ-008 While ProgMode=0 and reset is high, each rising clk SHALL write Data_Prog to imem[Addr_Prog]; PC SHALL hold at 0 and the pipeline SHALL hold NOPs.
REQ-009 While ProgMode=1, the core SHALL execute from imem as a 5-stage pipeline (IF, ID, EX, MEM, WB), one fetch per cycle, starting at PC=0; imem writes are ignored.
REQ-010 Fields: op=[31:26], A=[25:21], B=[20:16], C=[15:11], funct=[5:0], imm=[15:0].
REQ-011 op 0x00 R-type, R[A] = R[B] op R[C]: funct 0x08 AND, 0x19 SRL (R[B] >> R[C][4:0], logical), 0x20 ADD, 0x22 SUB, 0x25 OR, 0x26 XOR, 0x2A SLT (signed, result 1/0); other funct = NOP.
REQ-012 op 0x04 ADDI: R[A] = R[B] + signext(imm); 32-bit wrap, no overflow trap.
REQ-013 op 0x01 LW: R[A] = dmem[(R[B] + signext(imm))[7:0]].
REQ-014 op 0x02 SW: dmem[(R[B] + signext(imm))[7:0]] = R[A], written at the rising edge ending MEM.
REQ-015 op 0x0D BNE: if R[A] != R[B], PC = imm[7:0] (absolute address).
REQ-016 op 0x3F JMP: PC = imm[7:0] unconditionally; JMP to its own address is the halt idiom.
REQ-017 Unknown opcodes SHALL execute as NOP with no register or memory write.
REQ-018 PC SHALL increment by 1 per fetch (8-bit word address), wrapping 255 -> 0.
REQ-019 BNE and JMP SHALL resolve in EX; on a taken transfer the two younger instructions (IF/ID, ID/EX) SHALL be flushed to NOP; there is no delay slot.
REQ-020 Forwarding from EX/MEM and MEM/WB into EX operands (including BNE compares and SW store data) SHALL be provided; EX/MEM has priority; writes to R0 are never forwarded.
REQ-021 The register file SHALL bypass a same-cycle WB write to an ID read of the same register.
REQ-022 Load-use hazard (LW in EX, dependent instruction in ID) SHALL stall PC and IF/ID one cycle and insert one bubble into ID/EX.
REQ-023 A non-dependent instruction SHALL write back 4 cycles after its fetch edge; throughput is 1 instruction per cycle absent stalls and flushes.

Reset
REQ-024 reset=0 SHALL immediately clear PC to 0, all pipeline registers to NOP, and all registers to 0.
REQ-025 reset SHALL NOT alter imem or dmem contents.
REQ-026 Asserting reset mid-execution SHALL abort all in-flight instructions; after release, execution restarts at PC=0 with imem intact.

Verification
REQ-027 Load imem[0..10] = 0x10600DDE, 0x10400000, 0x10200001, 0x00811808, 0x34810006, 0x10420001, 0x00630819, 0x3460000D->0x34600003, 0x08400005, 0x06000005, 0xFC00000A with ProgMode=0; pulse reset, set ProgMode=1 -> R2=9, R3=0, dmem[5]=9, R16=9, PC loops at address 10-12 (halt).
REQ-028 ADDI R1,R0,5; ADDI R1,R1,1; ADD R2,R1,R1 back-to-back -> R1=6, R2=12 with no stall cycles.
REQ-029 SW R1 (=7) to dmem[3], LW R4 from dmem[3], ADDI R5,R4,1 -> exactly one stall cycle, R5=8.
REQ-030 Taken BNE followed by two ADDI R6 instructions -> both flushed, R6 stays 0; a not-taken BNE causes no flush.
REQ-031 Assert reset during the REQ-027 run -> PC=0 and registers 0 immediately; after release the run completes with the same final values.
REQ-032 Write R0 with ADDI R0,R0,5, then ADD R7,R0,R0 -> R0=0, R7=0.
